vita_tx_burst_arbiter: RTL and testbench
========================================

Name: vita_tx_burst_arbiter

Overview:
- Shares one vita_tx_control sample input between two vita_tx_deframer sample FIFOs (e.g. two host streams onto one DAC chain).
- Grant is burst-granular: once a port wins, it keeps the datapath until its end-of-burst word is consumed, or until a hold timeout expires between packets of the burst.
- Round-robin or fixed-priority policy, per-port enables and the hold timeout come from one settings register.

Parameters:
BASE, 0, settings-bus address of the config register
WIDTH, 32, sample width; FIFO word width is DW = 5+64+16+WIDTH

Ports:
clk  in  1  single clock domain (DSP/DAC clock)
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous soft reset
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
in0_data  in  DW  port 0 word; eop=bit 80, eob=bit 81, sob=bit 82
in0_src_rdy  in  1  port 0 valid
in0_dst_rdy  out  1  port 0 ready
in1_data  in  DW  port 1 word, same layout
in1_src_rdy  in  1  port 1 valid
in1_dst_rdy  out  1  port 1 ready
out_data  out  DW  to vita_tx_control sample_fifo_i
out_src_rdy  out  1  output valid
out_dst_rdy  in  1  output ready
grant  out  1  granted port index (valid when busy=1)
busy  out  1  state is BURST or HOLD
timeout_err  out  1  one-cycle pulse when a hold timeout releases a grant
burst_count0  out  16  completed bursts, port 0, wraps
burst_count1  out  16  completed bursts, port 1, wraps
debug  out  32  {state[1:0], grant, last, in*_src_rdy, in*_dst_rdy, out_src_rdy, out_dst_rdy, hold_cnt[15:0], zero pad}

Behaviour:
- Config register is at BASE, written via setting_reg and reset to 0:
  - bit0 = en0, bit1 = en1.
  - bit2 = mode: 0 = round-robin, 1 = fixed priority to port 0.
  - [31:16] = hold timeout in cycles; 0 means no timeout.
- All flops reset asynchronously on reset. clear acts synchronously with the same values.
- Reset/clear values:
  - state=IDLE, grant=0, last=1 (port 0 wins the first tie), busy=0, timeout_err=0.
  - hold_cnt=0, burst counts=0.
  - out_src_rdy=0 and both in*_dst_rdy=0.
- A transfer occurs on a port when src_rdy & dst_rdy are both high on a rising clk edge.
- Datapath is a combinational mux with zero latency:
  - In BURST: out_data = in[grant]_data; out_src_rdy = in[grant]_src_rdy; in[grant]_dst_rdy = out_dst_rdy.
  - The non-granted port's dst_rdy is held 0.
  - In IDLE and HOLD: out_src_rdy=0, both dst_rdy=0, out_data = in[grant]_data.
- State IDLE: request r_n = in_n_src_rdy & en_n.
  - If neither requests: stay.
  - If one requests: grant it.
  - If both request, mode=1: grant port 0.
  - If both request, mode=0: grant ~last.
  - On any grant, the next state is BURST and grant is registered. There is a 1-cycle arbitration bubble; no data passes in the IDLE cycle.
- State BURST:
  - Transfer with eop & eob: go to IDLE, set last=grant, increment burst_count[grant] (16-bit wrap).
  - Transfer with eop & ~eob: go to HOLD, load hold_cnt = timeout.
  - Otherwise stay; stall on ~src_rdy indefinitely. Underrun inside a packet is vita_tx_control's job.
- State HOLD:
  - If en[grant]=0: go to IDLE, set last=grant. No timeout_err.
  - Else if in[grant]_src_rdy: go to BURST. Data passes from the next cycle.
  - Else if timeout≠0 and hold_cnt==1: go to IDLE, set last=grant, pulse timeout_err for 1 cycle. The burst is not counted.
  - Else decrement hold_cnt when timeout≠0.
- Enable changes are sampled in IDLE and HOLD only. Disabling a port during BURST still lets the current packet complete.
- A config write mid-burst takes effect at the next HOLD load or IDLE decision.
- Simultaneous events:
  - If the eop&eob transfer and a new request from the other port arrive in the same cycle, the new request is arbitrated in the following IDLE cycle.
  - clear overrides everything.
  - Asserting reset mid-burst drops the grant immediately and blocks both inputs.

Test Plan:
- Config en0=en1=1, mode=0. Port 0 sends a 1-packet burst of 4 words. → Output matches in0 word-for-word. Grant=0. After the eob word: IDLE, burst_count0=1.
- Both ports hold 2-word eob packets continuously, mode=0. → Grants alternate 0,1,0,1. Each burst is followed by exactly one idle cycle. The counts advance equally.
- Same traffic with mode=1. → Only port 0 is granted and burst_count1 stays 0. Drop en0 → port 1 is granted at the next IDLE.
- Timeout=5. Port 0 sends an eop-without-eob packet then goes silent while port 1 requests. → timeout_err pulses 5 cycles after the HOLD entry, then port 1 is granted. With timeout=0, port 0 holds indefinitely.
- Port 0 packet, 12-cycle gap, second packet with eob; timeout=20. → The grant is kept across the gap, burst_count0 increments once, no timeout_err.
- Assert reset asynchronously mid-packet, and separately pulse clear mid-packet. → Outputs take reset values immediately (reset) or at the next edge (clear). With counts preset to 0xFFFF, the following bursts wrap the count to 0x0000.

Source files
------------

// File: rtl/vita_tx_burst_arbiter.sv
// Shares one vita_tx_control sample input between two deframer FIFOs, granting whole bursts.
// Latency: zero-cycle combinational datapath; one idle arbitration cycle precedes every burst.
// Backpressure: out_dst_rdy goes straight to the granted port; the other port (and both outside BURST) sees 0.
module vita_tx_burst_arbiter #(
    parameter int BASE  = 0,
    parameter int WIDTH = 32,
    localparam int DW   = 5 + 64 + 16 + WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          set_stb,
    input  logic [7:0]    set_addr,
    input  logic [31:0]   set_data,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_src_rdy,
    output logic          in0_dst_rdy,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_src_rdy,
    output logic          in1_dst_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_src_rdy,
    input  logic          out_dst_rdy,
    output logic          grant,
    output logic          busy,
    output logic          timeout_err,
    output logic [15:0]   burst_count0,
    output logic [15:0]   burst_count1,
    output logic [31:0]   debug
);

    localparam int EOP_BIT = 80;
    localparam int EOB_BIT = 81;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        tmo_err_q, tmo_err_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic [31:0] cfg_q, cfg_d;

    logic          en0, en1, mode;
    logic [15:0]   timeout;
    logic          req0, req1;
    logic [DW-1:0] sel_data;
    logic          sel_src_rdy, sel_en, sel_eop, sel_eob;
    logic          in_burst, xfer;

    assign en0     = cfg_q[0];
    assign en1     = cfg_q[1];
    assign mode    = cfg_q[2];
    assign timeout = cfg_q[31:16];

    assign req0 = in0_src_rdy & en0;
    assign req1 = in1_src_rdy & en1;

    // The mux always follows the registered grant so out_data is stable even while idle.
    assign sel_data    = grant_q ? in1_data : in0_data;
    assign sel_src_rdy = grant_q ? in1_src_rdy : in0_src_rdy;
    assign sel_en      = grant_q ? en1 : en0;
    assign sel_eop     = sel_data[EOP_BIT];
    assign sel_eob     = sel_data[EOB_BIT];

    assign in_burst    = (state_q == ST_BURST);
    assign out_data    = sel_data;
    assign out_src_rdy = in_burst & sel_src_rdy;
    assign in0_dst_rdy = in_burst & ~grant_q & out_dst_rdy;
    assign in1_dst_rdy = in_burst & grant_q & out_dst_rdy;
    assign xfer        = out_src_rdy & out_dst_rdy;

    assign grant        = grant_q;
    assign busy         = (state_q == ST_BURST) | (state_q == ST_HOLD);
    assign timeout_err  = tmo_err_q;
    assign burst_count0 = cnt0_q;
    assign burst_count1 = cnt1_q;
    assign debug = {state_q, grant_q, last_q, in0_src_rdy, in1_src_rdy, in0_dst_rdy, in1_dst_rdy,
                    out_src_rdy, out_dst_rdy, hold_cnt_q, 6'd0};

    // Settings register: enables, policy and hold timeout.
    always_comb begin
        cfg_d = cfg_q;
        if (set_stb && (set_addr == 8'(BASE))) begin
            cfg_d = set_data;
        end
        if (clear) begin
            cfg_d = '0;
        end
    end

    // Burst arbitration FSM; enables are only looked at in IDLE and HOLD so a packet in flight always completes.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        tmo_err_d  = 1'b0;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d = ST_BURST;
                    if (req0 & req1) begin
                        grant_d = mode ? 1'b0 : ~last_q;
                    end else begin
                        grant_d = req1;
                    end
                end
            end
            ST_BURST: begin
                if (xfer && sel_eop) begin
                    if (sel_eob) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                        if (grant_q) begin
                            cnt1_d = cnt1_q + 16'd1;
                        end else begin
                            cnt0_d = cnt0_q + 16'd1;
                        end
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = timeout;
                    end
                end
            end
            ST_HOLD: begin
                if (!sel_en) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (sel_src_rdy) begin
                    state_d = ST_BURST;
                end else if (timeout != 16'd0) begin
                    if (hold_cnt_q == 16'd1) begin
                        // Abandoned burst: release the grant without counting it.
                        state_d   = ST_IDLE;
                        last_d    = grant_q;
                        tmo_err_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d    = ST_IDLE;
            grant_d    = 1'b0;
            last_d     = 1'b1;
            hold_cnt_d = '0;
            tmo_err_d  = 1'b0;
            cnt0_d     = '0;
            cnt1_d     = '0;
        end
    end

    // State registers; last resets to 1 so port 0 wins the first round-robin tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            tmo_err_q  <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_err_q  <= tmo_err_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            cfg_q      <= cfg_d;
        end
    end

endmodule

// File: tb/tb_vita_tx_burst_arbiter.sv
// Scoreboard bench for vita_tx_burst_arbiter: directed bursts on two ports, output words checked in order.
// Inputs change at posedge+1 (port drivers) or negedge+2 (control); outputs are sampled at negedge+4.
// Expected words are queued as stimulus is issued and popped by an independent output monitor.
module tb_vita_tx_burst_arbiter;

    localparam int DW = 117;

    logic          clk = 1'b0;
    logic          reset, clear, set_stb;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic          in0_src_rdy, in0_dst_rdy, in1_src_rdy, in1_dst_rdy;
    logic          out_src_rdy, out_dst_rdy;
    logic          grant, busy, timeout_err;
    logic [15:0]   burst_count0, burst_count1;
    logic [31:0]   debug;

    always #5 clk = ~clk;

    vita_tx_burst_arbiter #(.BASE(0), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .in0_data(in0_data), .in0_src_rdy(in0_src_rdy), .in0_dst_rdy(in0_dst_rdy),
        .in1_data(in1_data), .in1_src_rdy(in1_src_rdy), .in1_dst_rdy(in1_dst_rdy),
        .out_data(out_data), .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
        .grant(grant), .busy(busy), .timeout_err(timeout_err),
        .burst_count0(burst_count0), .burst_count1(burst_count1), .debug(debug)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int tmo_pulses = 0;
    logic [DW-1:0] src0[$];
    logic [DW-1:0] src1[$];
    logic [DW:0]   exp_q[$];
    int            xfer_cyc[$];

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [DW-1:0] mkw(input logic [31:0] id, input logic eop, input logic eob);
        logic [DW-1:0] w;
        w = '0;
        w[31:0]   = id;
        w[63:32]  = ~id;
        w[80]     = eop;
        w[81]     = eob;
        w[116:85] = id ^ 32'hA5A5_5A5A;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic write_cfg(input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = 8'd0;
        set_data = d;
        step();
        set_stb  = 1'b0;
    endtask

    task automatic push(input logic port, input logic [DW-1:0] w, input bit expect_it);
        if (port) src1.push_back(w);
        else      src0.push_back(w);
        if (expect_it) exp_q.push_back({port, w});
    endtask

    task automatic wait_exp(input int n, input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() <= n) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: %0d words still pending, expected at most %0d", name, exp_q.size(), n);
        exp_q.delete();
    endtask

    // Port drivers: pop a word once its handshake has been seen, then present the next one.
    initial begin
        bit x0, x1;
        in0_src_rdy = 1'b0; in1_src_rdy = 1'b0;
        in0_data = '0; in1_data = '0;
        forever begin
            @(negedge clk); #4;
            x0 = in0_src_rdy && in0_dst_rdy;
            x1 = in1_src_rdy && in1_dst_rdy;
            @(posedge clk); #1;
            if (x0 && src0.size() > 0) src0.delete(0);
            if (x1 && src1.size() > 0) src1.delete(0);
            if (src0.size() > 0) begin in0_src_rdy = 1'b1; in0_data = src0[0]; end
            else begin in0_src_rdy = 1'b0; in0_data = '0; end
            if (src1.size() > 0) begin in1_src_rdy = 1'b1; in1_data = src1[0]; end
            else begin in1_src_rdy = 1'b0; in1_data = '0; end
        end
    end

    // Output monitor: every accepted output word must match the head of the expected queue.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk); #4;
            if (timeout_err === 1'b1) tmo_pulses++;
            if (out_src_rdy === 1'b1 && out_dst_rdy === 1'b1) begin
                xfer_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got port %0d data %h expected no word", grant, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[DW-1:0] || grant !== e[DW]) begin
                        n_fail++;
                        $display("FAIL out_word: got port %0d data %h expected port %0d data %h",
                                 grant, out_data, e[DW], e[DW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w0, w1;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        out_dst_rdy = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_cnt0", 32'(burst_count0), 32'd0);
        chk("rst_cnt1", 32'(burst_count1), 32'd0);
        chk("rst_rdys", 32'({out_src_rdy, in0_dst_rdy, in1_dst_rdy}), 32'd0);
        chk("rst_debug", debug, 32'h1040_0000);

        // Single 4-word burst on port 0
        write_cfg(32'h0000_0003);
        for (int i = 0; i < 4; i++) push(1'b0, mkw(32'h100 + 32'(i), i == 3, i == 3), 1'b1);
        wait_exp(0, "t1_drain");
        chk("t1_grant", 32'(grant), 32'd0);
        step();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_cnt0", 32'(burst_count0), 32'd1);
        chk("t1_cnt1", 32'(burst_count1), 32'd0);

        // Clear between bursts, then round-robin with both ports always requesting
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_cnt0", 32'(burst_count0), 32'd0);
        write_cfg(32'h0000_0003);
        xfer_cyc.delete();
        for (int i = 0; i < 2; i++) begin
            w0 = mkw(32'h200 + 32'(2 * i), 1'b0, 1'b0);
            w1 = mkw(32'h201 + 32'(2 * i), 1'b1, 1'b1);
            push(1'b0, w0, 1'b1); push(1'b0, w1, 1'b1);
            w0 = mkw(32'h300 + 32'(2 * i), 1'b0, 1'b0);
            w1 = mkw(32'h301 + 32'(2 * i), 1'b1, 1'b1);
            push(1'b1, w0, 1'b1); push(1'b1, w1, 1'b1);
        end
        wait_exp(0, "t2_drain");
        step();
        chk("t2_cnt0", 32'(burst_count0), 32'd2);
        chk("t2_cnt1", 32'(burst_count1), 32'd2);
        chk("t2_nxfer", 32'(xfer_cyc.size()), 32'd8);
        if (xfer_cyc.size() == 8) begin
            chk("t2_inpkt", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
            for (int b = 1; b < 4; b++) chk("t2_bubble", 32'(xfer_cyc[2 * b] - xfer_cyc[2 * b - 1]), 32'd2);
        end

        // Fixed priority: port 0 keeps winning; disabling it mid-burst hands over at the next IDLE
        write_cfg(32'h0000_0007);
        for (int i = 0; i < 4; i++) push(1'b0, mkw(32'h400 + 32'(i), i[0], i[0]), 1'b1);
        push(1'b1, mkw(32'h500, 1'b0, 1'b0), 1'b1);
        push(1'b1, mkw(32'h501, 1'b1, 1'b1), 1'b1);
        push(1'b0, mkw(32'h404, 1'b0, 1'b0), 1'b0);
        push(1'b0, mkw(32'h405, 1'b1, 1'b1), 1'b0);
        wait_exp(3, "t3_prio");
        chk("t3_cnt0_mid", 32'(burst_count0), 32'd3);
        chk("t3_cnt1_mid", 32'(burst_count1), 32'd2);
        write_cfg(32'h0000_0006);
        wait_exp(0, "t3_handover");
        repeat (4) step();
        chk("t3_cnt0", 32'(burst_count0), 32'd4);
        chk("t3_cnt1", 32'(burst_count1), 32'd3);
        chk("t3_parked", 32'(busy), 32'd0);
        exp_q.push_back({1'b0, mkw(32'h404, 1'b0, 1'b0)});
        exp_q.push_back({1'b0, mkw(32'h405, 1'b1, 1'b1)});
        write_cfg(32'h0000_0003);
        wait_exp(0, "t3_reenable");
        step();
        chk("t3_cnt0_end", 32'(burst_count0), 32'd5);

        // Hold timeout of 5 cycles while port 1 waits
        write_cfg(32'h0005_0003);
        push(1'b0, mkw(32'h600, 1'b1, 1'b0), 1'b1);
        wait_exp(0, "t4_first");
        push(1'b1, mkw(32'h700, 1'b0, 1'b0), 1'b1);
        push(1'b1, mkw(32'h701, 1'b1, 1'b1), 1'b1);
        for (int k = 0; k <= 6; k++) begin
            chk("t4_tmo_pulse", 32'(timeout_err), 32'(k == 5));
            if (k <= 5) chk("t4_hold_busy", 32'(busy), 32'(k < 5));
            step();
        end
        wait_exp(0, "t4_drain");
        step();
        chk("t4_cnt0", 32'(burst_count0), 32'd5);
        chk("t4_cnt1", 32'(burst_count1), 32'd4);
        chk("t4_npulse", 32'(tmo_pulses), 32'd1);

        // Timeout disabled: port 0 holds through a long gap
        write_cfg(32'h0000_0003);
        push(1'b0, mkw(32'h800, 1'b1, 1'b0), 1'b1);
        wait_exp(0, "t5_first");
        push(1'b1, mkw(32'h900, 1'b0, 1'b0), 1'b0);
        push(1'b1, mkw(32'h901, 1'b1, 1'b1), 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 9) chk("t5_held", 32'({busy, grant}), 32'b10);
            step();
        end
        push(1'b0, mkw(32'h801, 1'b1, 1'b1), 1'b1);
        exp_q.push_back({1'b1, mkw(32'h900, 1'b0, 1'b0)});
        exp_q.push_back({1'b1, mkw(32'h901, 1'b1, 1'b1)});
        wait_exp(0, "t5_drain");
        step();
        chk("t5_cnt0", 32'(burst_count0), 32'd6);
        chk("t5_cnt1", 32'(burst_count1), 32'd5);
        chk("t5_npulse", 32'(tmo_pulses), 32'd1);

        // Timeout 20, 12-cycle gap between packets of one burst
        write_cfg(32'h0014_0003);
        xfer_cyc.delete();
        push(1'b0, mkw(32'hA00, 1'b1, 1'b0), 1'b1);
        wait_exp(0, "t6_first");
        push(1'b1, mkw(32'hB00, 1'b0, 1'b0), 1'b0);
        push(1'b1, mkw(32'hB01, 1'b1, 1'b1), 1'b0);
        repeat (12) step();
        push(1'b0, mkw(32'hA01, 1'b1, 1'b1), 1'b1);
        exp_q.push_back({1'b1, mkw(32'hB00, 1'b0, 1'b0)});
        exp_q.push_back({1'b1, mkw(32'hB01, 1'b1, 1'b1)});
        wait_exp(0, "t6_drain");
        step();
        chk("t6_cnt0", 32'(burst_count0), 32'd7);
        chk("t6_cnt1", 32'(burst_count1), 32'd6);
        chk("t6_npulse", 32'(tmo_pulses), 32'd1);
        if (xfer_cyc.size() >= 2) chk("t6_gap", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd15);
        else chk("t6_nxfer", 32'(xfer_cyc.size()), 32'd4);

        // Asynchronous reset in the middle of a packet
        write_cfg(32'h0000_0003);
        push(1'b0, mkw(32'hC00, 1'b0, 1'b0), 1'b1);
        push(1'b0, mkw(32'hC01, 1'b0, 1'b0), 1'b1);
        push(1'b0, mkw(32'hC02, 1'b1, 1'b1), 1'b0);
        wait_exp(0, "t7_mid");
        #1 reset = 1'b1;
        #1;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_rdys", 32'({out_src_rdy, in0_dst_rdy, in1_dst_rdy}), 32'd0);
        chk("t7_cnt0", 32'(burst_count0), 32'd0);
        chk("t7_debug", 32'(debug[31:22]), 32'b00_0_1_1_0_0_0_0_1);
        src0.delete();
        src1.delete();
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        chk("t7_after", 32'(busy), 32'd0);

        // Synchronous clear in the middle of a packet
        write_cfg(32'h0000_0003);
        push(1'b0, mkw(32'hD00, 1'b0, 1'b0), 1'b1);
        push(1'b0, mkw(32'hD01, 1'b0, 1'b0), 1'b1);
        push(1'b0, mkw(32'hD02, 1'b1, 1'b1), 1'b1);
        wait_exp(1, "t8_mid");
        clear = 1'b1;
        #1;
        chk("t8_before_edge", 32'(busy), 32'd1);
        step();
        clear = 1'b0;
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_cnt0", 32'(burst_count0), 32'd0);
        chk("t8_out_vld", 32'(out_src_rdy), 32'd0);
        chk("t8_last", 32'(debug[28]), 32'd1);

        // Counter wrap from 0xFFFF
        write_cfg(32'h0000_0003);
        force dut.cnt0_q = 16'hFFFF;
        force dut.cnt1_q = 16'hFFFF;
        #1;
        release dut.cnt0_q;
        release dut.cnt1_q;
        push(1'b0, mkw(32'hE00, 1'b1, 1'b1), 1'b1);
        push(1'b1, mkw(32'hF00, 1'b1, 1'b1), 1'b1);
        wait_exp(0, "t9_drain");
        repeat (2) step();
        chk("t9_wrap0", 32'(burst_count0), 32'd0);
        chk("t9_wrap1", 32'(burst_count1), 32'd0);

        chk("end_pending", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
